// File: rtl/fwd_pkg.sv
// Shared constants, types and helpers for the forwarding / hazard unit.
package fwd_pkg;

    // Forward select value meaning "read the register file".
    localparam int unsigned SEL_REGFILE = 32'd0;

    // Packed operand index, wide enough for any practical NUM_SRC.
    typedef logic [7:0] src_idx_t;

    // Select value that picks the HF result bypass.
    function automatic int unsigned SEL_HF(input int unsigned num_stg);
        return num_stg + 32'd1;
    endfunction

    // Width of one forward select: regfile + NUM_STG stages + HF bypass.
    function automatic int unsigned sel_w(input int unsigned num_stg);
        return $clog2(num_stg + 32'd2);
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Priority selector for a single EX operand: HF bypass first, then the
// youngest matching write-back stage, otherwise the register file.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_STG = 32'd2,
    parameter int unsigned REG_W   = 32'd5,
    parameter int unsigned SEL_W   = sel_w(NUM_STG)
) (
    input  logic                     src_vld,
    input  logic [REG_W-1:0]         src_reg,
    input  logic [NUM_STG-1:0]       stg_wr_en,
    input  logic [NUM_STG*REG_W-1:0] stg_rd,
    input  logic                     hf_done,
    input  logic [REG_W-1:0]         hf_done_rd,
    output logic [SEL_W-1:0]         sel
);

    logic [SEL_W-1:0] sel_s;
    logic             hit_s;

    // Pick the forwarding source; r0 and unused operands never forward.
    always_comb begin
        sel_s = SEL_W'(SEL_REGFILE);
        hit_s = 1'b0;
        if (!src_vld || (src_reg == {REG_W{1'b0}})) begin
            sel_s = SEL_W'(SEL_REGFILE);
        end else if (hf_done && (hf_done_rd == src_reg)) begin
            sel_s = SEL_W'(SEL_HF(NUM_STG));
        end else begin
            for (int k = 0; k < NUM_STG; k++) begin
                if (!hit_s && stg_wr_en[k] && (stg_rd[k*REG_W +: REG_W] == src_reg)) begin
                    sel_s = SEL_W'(k + 1);
                    hit_s = 1'b1;
                end else begin
                    sel_s = sel_s;
                end
            end
        end
    end

    assign sel = sel_s;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit with a scoreboard for the multi-cycle HF unit.
// Optional build macro FWD_PERF_CNT_EN adds saturating stall / forward
// performance counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W   = 32'd5,
    parameter int unsigned NUM_SRC = 32'd3,
    parameter int unsigned NUM_STG = 32'd2,
    parameter int unsigned HF_LAT  = 32'd4,
    parameter int unsigned SEL_W   = sel_w(NUM_STG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_STG-1:0]       stg_wr_en,
    input  logic [NUM_STG*REG_W-1:0] stg_rd,
    input  logic [NUM_SRC-1:0]       src_vld,
    input  logic [NUM_SRC*REG_W-1:0] src_reg,
    input  logic                     id_ex_vld,
    input  logic                     hf_issue,
    input  logic [REG_W-1:0]         hf_rd,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall,
    output logic                     hf_busy,
    output logic                     hf_done,
    output logic [REG_W-1:0]         hf_done_rd
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_fwd_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(HF_LAT + 32'd1);

    logic [NUM_SRC*SEL_W-1:0] sel_raw_s;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_nxt_s;
    logic [REG_W-1:0]         pend_rd_r;
    logic [REG_W-1:0]         pend_nxt_s;
    logic                     hf_busy_r;
    logic                     hf_done_r;
    logic [REG_W-1:0]         hf_done_rd_r;
    logic                     raw_s;
    logic                     struct_s;
    logic                     stall_s;
    logic                     accept_s;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        fwd_src_sel #(
            .NUM_STG (NUM_STG),
            .REG_W   (REG_W),
            .SEL_W   (SEL_W)
        ) u_src_sel (
            .src_vld    (src_vld[j]),
            .src_reg    (src_reg[j*REG_W +: REG_W]),
            .stg_wr_en  (stg_wr_en),
            .stg_rd     (stg_rd),
            .hf_done    (hf_done_r),
            .hf_done_rd (hf_done_rd_r),
            .sel        (sel_raw_s[j*SEL_W +: SEL_W])
        );
    end

    // RAW hazard: a valid operand waits on the in-flight HF destination.
    always_comb begin
        raw_s = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (src_vld[j] && (src_reg[j*REG_W +: REG_W] == pend_rd_r)) begin
                raw_s = 1'b1;
            end else begin
                raw_s = raw_s;
            end
        end
        raw_s = raw_s & hf_busy_r & ~hf_done_r & (pend_rd_r != {REG_W{1'b0}});
    end

    // Stall / forward outputs, both forced quiet while in reset.
    always_comb begin
        struct_s  = hf_issue & hf_busy_r & ~hf_done_r;
        stall_s   = 1'b0;
        fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        if (rst) begin
            stall_s   = 1'b0;
            fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        end else begin
            stall_s   = id_ex_vld & (raw_s | struct_s);
            fwd_sel_s = sel_raw_s;
        end
    end

    // Scoreboard next state: reload on an accepted issue, else count down to 0.
    always_comb begin
        accept_s   = id_ex_vld & hf_issue & ~stall_s;
        cnt_nxt_s  = {CNT_W{1'b0}};
        pend_nxt_s = pend_rd_r;
        if (accept_s) begin
            cnt_nxt_s  = CNT_W'(HF_LAT);
            pend_nxt_s = hf_rd;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_nxt_s  = cnt_r - CNT_W'(1);
            pend_nxt_s = pend_rd_r;
        end else begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            pend_nxt_s = pend_rd_r;
        end
    end

    // Scoreboard registers; busy/done are registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= {CNT_W{1'b0}};
            pend_rd_r    <= {REG_W{1'b0}};
            hf_busy_r    <= 1'b0;
            hf_done_r    <= 1'b0;
            hf_done_rd_r <= {REG_W{1'b0}};
        end else begin
            cnt_r        <= cnt_nxt_s;
            pend_rd_r    <= pend_nxt_s;
            hf_busy_r    <= (cnt_nxt_s != {CNT_W{1'b0}});
            hf_done_r    <= (cnt_nxt_s == CNT_W'(1));
            hf_done_rd_r <= (cnt_nxt_s == CNT_W'(1)) ? pend_nxt_s : {REG_W{1'b0}};
        end
    end

    assign fwd_sel    = fwd_sel_s;
    assign stall      = stall_s;
    assign hf_busy    = hf_busy_r;
    assign hf_done    = hf_done_r;
    assign hf_done_rd = hf_done_rd_r;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_fwd_cnt_r;

    // Saturating counts of stall cycles and of unstalled forwarding cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_r <= 32'd0;
            perf_fwd_cnt_r   <= 32'd0;
        end else begin
            if (stall_s && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (!stall_s && (|fwd_sel_s) && (perf_fwd_cnt_r != 32'hFFFF_FFFF)) begin
                perf_fwd_cnt_r <= perf_fwd_cnt_r + 32'd1;
            end else begin
                perf_fwd_cnt_r <= perf_fwd_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_fwd_cnt   = perf_fwd_cnt_r;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (REG_W=5, NUM_SRC=3, NUM_STG=2,
// HF_LAT=4). Expected values are queued when stimulus is driven and popped
// when the outputs are sampled on the falling edge.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  stg_wr_en;
    logic [9:0]  stg_rd;
    logic [2:0]  src_vld;
    logic [14:0] src_reg;
    logic        id_ex_vld;
    logic        hf_issue;
    logic [4:0]  hf_rd;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic        hf_busy;
    logic        hf_done;
    logic [4:0]  hf_done_rd;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    fwd_hazard_unit #(
        .REG_W   (5),
        .NUM_SRC (3),
        .NUM_STG (2),
        .HF_LAT  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stg_wr_en  (stg_wr_en),
        .stg_rd     (stg_rd),
        .src_vld    (src_vld),
        .src_reg    (src_reg),
        .id_ex_vld  (id_ex_vld),
        .hf_issue   (hf_issue),
        .hf_rd      (hf_rd),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .hf_busy    (hf_busy),
        .hf_done    (hf_done),
        .hf_done_rd (hf_done_rd)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] fwd;
        logic       stl;
        logic       busy;
        logic       done;
        logic [4:0] drd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Forwarding pattern table.
    logic [1:0]  pat_wr  [6] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    logic [9:0]  pat_rd  [6] = '{{5'd7, 5'd7}, {5'd7, 5'd7}, {5'd0, 5'd0},
                                 {5'd7, 5'd7}, {5'd3, 5'd7}, {5'd7, 5'd7}};
    logic [2:0]  pat_vld [6] = '{3'b001, 3'b001, 3'b111, 3'b000, 3'b111, 3'b111};
    logic [14:0] pat_src [6] = '{{5'd0, 5'd0, 5'd7}, {5'd0, 5'd0, 5'd7}, {5'd0, 5'd0, 5'd0},
                                 {5'd7, 5'd7, 5'd7}, {5'd4, 5'd3, 5'd7}, {5'd7, 5'd7, 5'd7}};
    logic [5:0]  pat_exp [6] = '{6'b00_00_01, 6'b00_00_10, 6'b00_00_00,
                                 6'b00_00_00, 6'b00_10_01, 6'b01_01_01};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        stg_wr_en = 2'b00;
        stg_rd    = 10'd0;
        src_vld   = 3'b000;
        src_reg   = 15'd0;
        id_ex_vld = 1'b0;
        hf_issue  = 1'b0;
        hf_rd     = 5'd0;
    endtask

    task automatic push_exp(input logic [5:0] f, input logic s, input logic b,
                            input logic d, input logic [4:0] r);
        exp_t e;
        e.fwd = f; e.stl = s; e.busy = b; e.done = d; e.drd = r;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            stg_wr_en = 2'($urandom);
            stg_rd    = 10'($urandom);
            src_vld   = 3'($urandom);
            src_reg   = 15'($urandom);
            id_ex_vld = 1'($urandom);
            hf_issue  = 1'($urandom);
            hf_rd     = 5'($urandom);
            push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks += 5;
            if (fwd_sel !== e.fwd) begin n_errors++; $display("FAIL reset_fwd c%0d: got %b want %b", i, fwd_sel, e.fwd); end
            if (stall !== e.stl) begin n_errors++; $display("FAIL reset_stall c%0d: got %b want %b", i, stall, e.stl); end
            if (hf_busy !== e.busy) begin n_errors++; $display("FAIL reset_busy c%0d: got %b want %b", i, hf_busy, e.busy); end
            if (hf_done !== e.done) begin n_errors++; $display("FAIL reset_done c%0d: got %b want %b", i, hf_done, e.done); end
            if (hf_done_rd !== e.drd) begin n_errors++; $display("FAIL reset_done_rd c%0d: got %0d want %0d", i, hf_done_rd, e.drd); end
        end
        next_cycle();
        rst = 1'b0;
        set_idle();
        push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks += 2;
        if (hf_busy !== e.busy) begin n_errors++; $display("FAIL release_busy: got %b want %b", hf_busy, e.busy); end
        if (hf_done !== e.done) begin n_errors++; $display("FAIL release_done: got %b want %b", hf_done, e.done); end
    endtask

    task automatic test_forwarding();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            set_idle();
            stg_wr_en = pat_wr[i];
            stg_rd    = pat_rd[i];
            src_vld   = pat_vld[i];
            src_reg   = pat_src[i];
            id_ex_vld = 1'b1;
            push_exp(pat_exp[i], 1'b0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks += 2;
            if (fwd_sel !== e.fwd) begin n_errors++; $display("FAIL fwd_pat%0d: got %b want %b", i, fwd_sel, e.fwd); end
            if (stall !== e.stl) begin n_errors++; $display("FAIL fwd_pat%0d_stall: got %b want %b", i, stall, e.stl); end
        end
    endtask

    // Issue r9, dependent op on operand 1; a younger stage-0 write to r9
    // (WAW) must not end the stall, and HF bypass outranks the stage.
    task automatic test_hf_raw();
        exp_t e;
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            set_idle();
            id_ex_vld = 1'b1;
            case (c)
                0: begin
                    hf_issue = 1'b1; hf_rd = 5'd9;
                    push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
                end
                1, 2, 3, 4, 5: begin
                    src_vld = 3'b010;
                    src_reg = {5'd0, 5'd9, 5'd0};
                    if (c >= 2) begin stg_wr_en = 2'b01; stg_rd = {5'd0, 5'd9}; end
                    if (c <= 3)      push_exp(6'b00_00_00, 1'b1, 1'b1, 1'b0, 5'd0);
                    else if (c == 4) push_exp(6'b00_11_00, 1'b0, 1'b1, 1'b1, 5'd9);
                    else             push_exp(6'b00_01_00, 1'b0, 1'b0, 1'b0, 5'd0);
                end
                default: push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks += 3;
            if (stall !== e.stl) begin n_errors++; $display("FAIL raw_stall T+%0d: got %b want %b", c, stall, e.stl); end
            if (hf_busy !== e.busy) begin n_errors++; $display("FAIL raw_busy T+%0d: got %b want %b", c, hf_busy, e.busy); end
            if (hf_done !== e.done) begin n_errors++; $display("FAIL raw_done T+%0d: got %b want %b", c, hf_done, e.done); end
            if (c >= 4) begin
                n_checks += 2;
                if (fwd_sel !== e.fwd) begin n_errors++; $display("FAIL raw_fwd T+%0d: got %b want %b", c, fwd_sel, e.fwd); end
                if (hf_done_rd !== e.drd) begin n_errors++; $display("FAIL raw_done_rd T+%0d: got %0d want %0d", c, hf_done_rd, e.drd); end
            end
        end
    endtask

    // Structural stall on a second issue, then back-to-back acceptance.
    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c <= 9; c++) begin
            next_cycle();
            set_idle();
            case (c)
                0: begin
                    id_ex_vld = 1'b1; hf_issue = 1'b1; hf_rd = 5'd5;
                    push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
                end
                1:       push_exp(6'd0, 1'b0, 1'b1, 1'b0, 5'd0);
                2, 3, 4: begin
                    id_ex_vld = 1'b1; hf_issue = 1'b1; hf_rd = 5'd6;
                    if (c == 4) push_exp(6'd0, 1'b0, 1'b1, 1'b1, 5'd5);
                    else        push_exp(6'd0, 1'b1, 1'b1, 1'b0, 5'd0);
                end
                5, 6, 7: push_exp(6'd0, 1'b0, 1'b1, 1'b0, 5'd0);
                8:       push_exp(6'd0, 1'b0, 1'b1, 1'b1, 5'd6);
                default: push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks += 3;
            if (stall !== e.stl) begin n_errors++; $display("FAIL b2b_stall T+%0d: got %b want %b", c, stall, e.stl); end
            if (hf_busy !== e.busy) begin n_errors++; $display("FAIL b2b_busy T+%0d: got %b want %b", c, hf_busy, e.busy); end
            if (hf_done !== e.done) begin n_errors++; $display("FAIL b2b_done T+%0d: got %b want %b", c, hf_done, e.done); end
            if (e.done) begin
                n_checks++;
                if (hf_done_rd !== e.drd) begin n_errors++; $display("FAIL b2b_done_rd T+%0d: got %0d want %0d", c, hf_done_rd, e.drd); end
            end
        end
    endtask

    // Reset two cycles after an issue drops the op without a done pulse.
    task automatic test_rst_mid();
        exp_t e;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            set_idle();
            rst = 1'b0;
            case (c)
                0: begin
                    id_ex_vld = 1'b1; hf_issue = 1'b1; hf_rd = 5'd11;
                    push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
                end
                1: push_exp(6'd0, 1'b0, 1'b1, 1'b0, 5'd0);
                2: begin
                    rst = 1'b1; id_ex_vld = 1'b1;
                    src_vld = 3'b001; src_reg = {5'd0, 5'd0, 5'd11};
                    stg_wr_en = 2'b01; stg_rd = {5'd0, 5'd11};
                    push_exp(6'd0, 1'b0, 1'b1, 1'b0, 5'd0);
                end
                default: push_exp(6'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            if (c == 2) begin
                n_checks += 2;
                if (stall !== e.stl) begin n_errors++; $display("FAIL rstmid_stall: got %b want %b", stall, e.stl); end
                if (fwd_sel !== e.fwd) begin n_errors++; $display("FAIL rstmid_fwd: got %b want %b", fwd_sel, e.fwd); end
            end else begin
                n_checks += 2;
                if (hf_busy !== e.busy) begin n_errors++; $display("FAIL rstmid_busy T+%0d: got %b want %b", c, hf_busy, e.busy); end
                if (hf_done !== e.done) begin n_errors++; $display("FAIL rstmid_done T+%0d: got %b want %b", c, hf_done, e.done); end
            end
        end
        rst = 1'b0;
    endtask

`ifdef FWD_PERF_CNT_EN
    // Scenario 3 again after a fresh reset, watching the perf counters.
    task automatic test_perf();
        next_cycle();
        set_idle();
        rst = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            set_idle();
            rst = 1'b0;
            id_ex_vld = 1'b1;
            if (c == 0) begin
                hf_issue = 1'b1; hf_rd = 5'd9;
            end else if (c <= 4) begin
                src_vld = 3'b010; src_reg = {5'd0, 5'd9, 5'd0};
            end else begin
                id_ex_vld = 1'b0;
            end
            @(negedge clk);
            if (c == 4) begin
                n_checks += 2;
                if (perf_stall_cnt !== 32'd3) begin n_errors++; $display("FAIL perf_stall T+4: got %0d want 3", perf_stall_cnt); end
                if (perf_fwd_cnt !== 32'd0) begin n_errors++; $display("FAIL perf_fwd T+4: got %0d want 0", perf_fwd_cnt); end
            end else if (c == 5) begin
                n_checks += 2;
                if (perf_stall_cnt !== 32'd3) begin n_errors++; $display("FAIL perf_stall T+5: got %0d want 3", perf_stall_cnt); end
                if (perf_fwd_cnt !== 32'd1) begin n_errors++; $display("FAIL perf_fwd T+5: got %0d want 1", perf_fwd_cnt); end
            end else begin
                n_checks = n_checks;
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_forwarding();
        test_hf_raw();
        test_back_to_back();
        test_rst_mid();
`ifdef FWD_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
